hamming_secded_rx: RTL

//  Parametrised, pipelined SECDED receiver: extended Hamming code with overall parity.

---
 rtl/hamming_pkg.sv | 39 +++
 rtl/hamming_syndrome.sv | 25 ++
 rtl/hamming_secded_rx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared types and elaboration-time helpers for the extended-Hamming SECDED datapath.
package hamming_pkg;

  // Error classification reported alongside each delivered word.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_CORR     = 2'b01,
    ERR_UNCORR   = 2'b10,
    ERR_PAR_ONLY = 2'b11
  } err_type_e;

  // Codeword width including the overall parity bit at position 0.
  function automatic int unsigned cw_w(input int unsigned r);
    return 32'd1 << r;
  endfunction

  // Number of payload bits carried by one codeword.
  function automatic int unsigned d_w(input int unsigned r);
    return (32'd1 << r) - r - 32'd1;
  endfunction

  function automatic logic is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 32'd1)) == 0);
  endfunction

  // Codeword position of data bit i: the i-th position >= 3 that is not a power of two.
  function automatic int unsigned data_pos(input int unsigned i);
    int unsigned n;
    int unsigned p;
    n = 0;
    p = 2;
    while (n <= i) begin
      p++;
      if (!is_pow2(p)) n++;
    end
    return p;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome/overall-parity generator for an extended Hamming codeword.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int unsigned R = 4
) (
  input  logic [cw_w(R)-1:0] i_cw,
  output logic [R-1:0]       o_syn,
  output logic               o_par
);

  localparam int unsigned CW_W = cw_w(R);

  // Syndrome is the XOR of the indices of every set bit above the overall-parity bit.
  always_comb begin
    o_syn = '0;
    for (int unsigned pos = 1; pos < CW_W; pos++) begin
      if (i_cw[pos]) o_syn = o_syn ^ R'(pos);
    end
  end

  // Overall parity across the whole codeword; 1 means an odd number of flips.
  assign o_par = ^i_cw;

endmodule

// File: rtl/hamming_secded_rx.sv
// Two-stage pipelined SECDED receiver with valid/ready handshakes and saturating error statistics.
module hamming_secded_rx
  import hamming_pkg::*;
#(
  parameter int unsigned R     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [cw_w(R)-1:0]   in_cw,
  input  logic                 in_detect_only,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [d_w(R)-1:0]    out_data,
  output logic [1:0]           out_err,
  output logic [R-1:0]         out_err_pos,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     corr_cnt,
  output logic [CNT_W-1:0]     uncorr_cnt
);

  localparam int unsigned D_W = d_w(R);

  // Pipeline control
  logic             w_adv1;
  logic             w_adv2;
  logic             w_out_hs;

  // Stage 1 inputs and registers
  logic [R-1:0]     w_syn;
  logic             w_par;
  logic [D_W-1:0]   w_in_data;
  logic             r_s1_valid;
  logic [D_W-1:0]   r_s1_data;
  logic [R-1:0]     r_s1_syn;
  logic             r_s1_par;
  logic             r_s1_det;

  // Stage 2 inputs and registers
  err_type_e        w_err;
  logic [R-1:0]     w_pos;
  logic             w_flip;
  logic [D_W-1:0]   w_fix_data;
  logic             r_out_valid;
  logic [D_W-1:0]   r_out_data;
  err_type_e        r_out_err;
  logic [R-1:0]     r_out_pos;

  // Statistics
  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_uncorr_cnt;
  logic             w_is_corr;
  logic             w_is_uncorr;

  hamming_syndrome #(.R(R)) u_syndrome (
    .i_cw  (in_cw),
    .o_syn (w_syn),
    .o_par (w_par)
  );

  // Each stage advances when its downstream slot is free or being drained this cycle.
  assign w_adv2   = !r_out_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign in_ready = w_adv1;
  assign w_out_hs = r_out_valid && out_ready;

  // Only data-bearing positions are carried past stage 1; parity positions are fully
  // summarised by the syndrome and overall parity, so the correction is applied per data bit.
  for (genvar gi = 0; gi < D_W; gi++) begin : g_bits
    localparam int unsigned POS = data_pos(gi);
    assign w_in_data[gi]  = in_cw[POS];
    assign w_fix_data[gi] = r_s1_data[gi] ^ (w_flip && (r_s1_syn == R'(POS)));
  end

  // Stage 1: capture payload bits, syndrome, overall parity and the per-word detect flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_syn   <= '0;
      r_s1_par   <= 1'b0;
      r_s1_det   <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= w_in_data;
        r_s1_syn  <= w_syn;
        r_s1_par  <= w_par;
        r_s1_det  <= in_detect_only;
      end
    end
  end

  // Classify the stage-1 word and decide whether a data bit gets flipped.
  always_comb begin
    w_err  = ERR_NONE;
    w_pos  = '0;
    w_flip = 1'b0;
    if (r_s1_syn != '0) begin
      if (r_s1_par) begin
        w_err  = ERR_CORR;
        w_pos  = r_s1_syn;
        w_flip = !r_s1_det;
      end else begin
        w_err  = ERR_UNCORR;
      end
    end else if (r_s1_par) begin
      w_err = ERR_PAR_ONLY;
    end
  end

  // Stage 2: output register; holds steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= ERR_NONE;
      r_out_pos   <= '0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_fix_data;
        r_out_err  <= w_err;
        r_out_pos  <= w_pos;
      end
    end
  end

  assign w_is_corr   = (r_out_err == ERR_CORR) || (r_out_err == ERR_PAR_ONLY);
  assign w_is_uncorr = (r_out_err == ERR_UNCORR);

  // Correctable-word counter: counts delivered words only, saturates, clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_corr_cnt <= '0;
    end else if (clr_cnt) begin
      r_corr_cnt <= '0;
    end else if (w_out_hs && w_is_corr && (r_corr_cnt != '1)) begin
      r_corr_cnt <= r_corr_cnt + 1'b1;
    end
  end

  // Uncorrectable-word counter: same rules as the correctable counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uncorr_cnt <= '0;
    end else if (clr_cnt) begin
      r_uncorr_cnt <= '0;
    end else if (w_out_hs && w_is_uncorr && (r_uncorr_cnt != '1)) begin
      r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_err     = r_out_err;
  assign out_err_pos = r_out_pos;
  assign corr_cnt    = r_corr_cnt;
  assign uncorr_cnt  = r_uncorr_cnt;

endmodule
